// File: rtl/bus_demux_pkg.sv
// ---------------------------------------------------------------------------
// bus_demux_pkg
// Shared types and constants for the MiniSys1A data-side bus demultiplexer.
// The instruction-side bus reuses these through bus_addr_decode.
//   state_e       : transaction FSM states (IDLE / REQ / WAIT / RESP)
//   IO_REGION_HI  : upper address half-word that marks the memory-mapped I/O page
//   TGT_RAM/TGT_IO: target indices returned by the address decoder
// ---------------------------------------------------------------------------
package bus_demux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam logic [15:0] IO_REGION_HI = 16'hFFFF;

   localparam logic TGT_RAM = 1'b0;
   localparam logic TGT_IO  = 1'b1;

endpackage

// File: rtl/bus_addr_decode.sv
// ---------------------------------------------------------------------------
// bus_addr_decode
// Purely combinational address decoder: the I/O page (upper half-word equal to
// IO_REGION_HI) goes to target 1, everything else goes to RAM (target 0).
// Only the upper half-word takes part in the decision, so that is all it takes.
// Ports:
//   addr_hi_i [15:0] : upper 16 bits of the request address
//   tgt_o            : selected target index (TGT_RAM or TGT_IO)
// ---------------------------------------------------------------------------
module bus_addr_decode
   import bus_demux_pkg::*;
(
   input  logic [15:0] addr_hi_i,
   output logic        tgt_o
);

   assign tgt_o = (addr_hi_i == IO_REGION_HI) ? TGT_IO : TGT_RAM;

endmodule

// File: rtl/bus_demux.sv
// ---------------------------------------------------------------------------
// bus_demux
// Single-master to two-target demultiplexer for the MiniSys1A data path.
// One request at a time is latched, forwarded to RAM (target 0) or to the I/O
// page (target 1), and the selected target's response is returned to the CPU
// as a one-cycle strobe. Every m_* output is a register or a decode of state,
// so no target input reaches the master side combinationally.
//
// Build option:
//   BUS_DEMUX_TIMEOUT_EN : when defined, a transaction stuck in REQ/WAIT is
//                          aborted with m_err = 1, and the RESP strobe lands
//                          TIMEOUT cycles after the accept. TIMEOUT must be >= 2.
//                          When undefined the block waits forever, m_err = 0.
//
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   m_req_valid/m_req_ready      : CPU request handshake
//   m_we, m_addr, m_wdata        : CPU request fields
//   m_rsp_valid, m_rdata, m_err  : CPU response strobe, load data, timeout flag
//   sN_req_valid/sN_req_ready    : request handshake to target N
//   sN_we, sN_addr, sN_wdata     : latched request fields to target N
//   sN_rsp_valid, sN_rdata       : response strobe and read data from target N
// ---------------------------------------------------------------------------
module bus_demux
   import bus_demux_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m_req_valid,
   output logic              m_req_ready,
   input  logic              m_we,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_wdata,
   output logic              m_rsp_valid,
   output logic [DATA_W-1:0] m_rdata,
   output logic              m_err,
   output logic              s0_req_valid,
   input  logic              s0_req_ready,
   output logic              s0_we,
   output logic [ADDR_W-1:0] s0_addr,
   output logic [DATA_W-1:0] s0_wdata,
   input  logic              s0_rsp_valid,
   input  logic [DATA_W-1:0] s0_rdata,
   output logic              s1_req_valid,
   input  logic              s1_req_ready,
   output logic              s1_we,
   output logic [ADDR_W-1:0] s1_addr,
   output logic [DATA_W-1:0] s1_wdata,
   input  logic              s1_rsp_valid,
   input  logic [DATA_W-1:0] s1_rdata
);

   state_e            state_q, state_d;
   logic              sel_q, sel_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              addr_tgt;
   logic              accept;
   logic              rsp_take;
   logic              timeout_hit;
   logic              tgt_req_ready;
   logic              tgt_rsp_valid;
   logic [DATA_W-1:0] tgt_rdata;

   bus_addr_decode u_decode (
      .addr_hi_i (m_addr[ADDR_W-1 -: 16]),
      .tgt_o     (addr_tgt)
   );

   // Only the latched target is ever looked at; the other target's strobes
   // are dropped here, which is what makes spurious responses harmless.
   assign tgt_req_ready = (sel_q == TGT_IO) ? s1_req_ready : s0_req_ready;
   assign tgt_rsp_valid = (sel_q == TGT_IO) ? s1_rsp_valid : s0_rsp_valid;
   assign tgt_rdata     = (sel_q == TGT_IO) ? s1_rdata     : s0_rdata;

   assign accept   = (state_q == IDLE) && m_req_valid;
   // A response counts in REQ only together with req_ready, which gives the
   // REQ -> RESP shortcut for targets that answer in the handshake cycle.
   assign rsp_take = ((state_q == REQ) && tgt_req_ready && tgt_rsp_valid) ||
                     ((state_q == WAIT) && tgt_rsp_valid);

`ifdef BUS_DEMUX_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;

   // count_q holds the number of cycles since accept (1 in the first REQ
   // cycle), so firing at TIMEOUT-1 puts the RESP strobe TIMEOUT cycles after
   // the accept.
   assign timeout_hit = ((state_q == REQ) || (state_q == WAIT)) &&
                        (count_q == CNT_W'(TIMEOUT - 1));

   // Timeout counter and error flag next state; a real response wins over an
   // expiring counter.
   always_comb begin
      count_d = count_q;
      err_d   = err_q;
      if (accept) begin
         count_d = CNT_W'(1);
         err_d   = 1'b0;
      end else if ((state_q == REQ) || (state_q == WAIT)) begin
         count_d = count_q + CNT_W'(1);
         if (!rsp_take && timeout_hit) begin
            err_d = 1'b1;
         end
      end
   end

   // Timeout counter and error flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign m_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign m_err       = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic for the one-outstanding-transaction sequence.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (m_req_valid) state_d = REQ;
         REQ: begin
            if (rsp_take)           state_d = RESP;
            else if (timeout_hit)   state_d = RESP;
            else if (tgt_req_ready) state_d = WAIT;
         end
         WAIT: if (rsp_take || timeout_hit) state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request fields latch only on accept so the target sees stable values for
   // the whole REQ phase; read data latches on the response (zero for stores)
   // or clears on a timeout abort.
   always_comb begin
      sel_d   = sel_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (accept) begin
         sel_d   = addr_tgt;
         we_d    = m_we;
         addr_d  = m_addr;
         wdata_d = m_wdata;
      end else if (rsp_take) begin
         rdata_d = we_q ? '0 : tgt_rdata;
      end else if (timeout_hit) begin
         rdata_d = '0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q   <= TGT_RAM;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         sel_q   <= sel_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decoded from state and the latched target only.
   always_comb begin
      m_req_ready  = (state_q == IDLE);
      m_rsp_valid  = (state_q == RESP);
      s0_req_valid = (state_q == REQ) && (sel_q == TGT_RAM);
      s1_req_valid = (state_q == REQ) && (sel_q == TGT_IO);
   end

   assign m_rdata  = rdata_q;
   assign s0_we    = we_q;
   assign s0_addr  = addr_q;
   assign s0_wdata = wdata_q;
   assign s1_we    = we_q;
   assign s1_addr  = addr_q;
   assign s1_wdata = wdata_q;

endmodule
